// File: rtl/ifu_prefetch_if.sv
// rtl/ifu_prefetch_if.sv - fetch unit bundle: redirect, imem request/response and decode handshake
interface ifu_prefetch_if #(
    parameter int DEPTH = 4
);
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [31:0]              imem_req_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic                     if_valid;
    logic                     if_ready;
    logic [31:0]              if_pc;
    logic [31:0]              if_instr;
    logic [$clog2(DEPTH):0]   fifo_count;

    // fetch unit side
    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr,
        input  if_ready,
        output fifo_count
    );

    // memory / decode / branch-unit side
    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr,
        output if_ready,
        input  fifo_count
    );
endinterface

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch with pipelined imem port and prefetch queue
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic           clock,
    input  logic           reset,
    ifu_prefetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t MAX_C   = cnt_t'(MAX_OUTSTANDING);

    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    cnt_t        outstanding;
    cnt_t        discard;
    cnt_t        count;
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic        req_fire;
    logic        push;
    logic        pop;
    logic        rsp_drop;
    logic [CW:0] reserved;
    cnt_t        req_inc;
    cnt_t        rsp_dec;
    cnt_t        push_inc;
    cnt_t        pop_dec;
    cnt_t        outstanding_nxt;
    logic        unused_pc_bits;

    // Every queued entry and every in-flight request holds a slot, so a
    // response can always be written without back-pressure.
    assign reserved = {1'b0, count} + {1'b0, outstanding};

    assign bus.imem_req_valid = !reset && !bus.redirect_valid
                              && (reserved < {1'b0, DEPTH_C})
                              && (outstanding < MAX_C);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop = bus.imem_rsp_valid && (discard != '0);
    assign push     = bus.imem_rsp_valid && (discard == '0) && !bus.redirect_valid;
    assign pop      = bus.if_valid && bus.if_ready;

    assign req_inc  = {{(CW-1){1'b0}}, req_fire};
    assign rsp_dec  = {{(CW-1){1'b0}}, bus.imem_rsp_valid};
    assign push_inc = {{(CW-1){1'b0}}, push};
    assign pop_dec  = {{(CW-1){1'b0}}, pop};

    assign outstanding_nxt = outstanding + req_inc - rsp_dec;

    assign bus.if_valid   = (count != '0) && !bus.redirect_valid;
    assign bus.if_pc      = pc_mem[rd_ptr];
    assign bus.if_instr   = instr_mem[rd_ptr];
    assign bus.fifo_count = count;

    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // Fetch/response PCs, request bookkeeping and queue pointers; a redirect
    // flushes the queue and marks everything still in flight as stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                rsp_pc   <= {bus.redirect_pc[31:2], 2'b00};
                discard  <= outstanding_nxt;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_drop) begin
                    discard <= discard - cnt_t'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                count <= count + push_inc - pop_dec;
            end
        end
    end

    // Queue storage: {pc, instr} written at the tail for each kept response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed table and sequence checks for ifu_prefetch
module tb_ifu_prefetch;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    ifu_prefetch_if #(.DEPTH(4)) bus ();

    ifu_prefetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(4),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_if;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    req_t pend[$];
    vec_t vq[$];
    int   cyc;
    int   lat;
    int   total;
    int   bad;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_if, input logic [31:0] e_pc, input int e_cnt);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_if = e_if; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    task automatic drive_cycle();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_fn(pend[0].addr);
            pend.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic end_cycle();
        req_t r;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            r.due  = cyc + lat;
            r.addr = bus.imem_req_addr;
            pend.push_back(r);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic cycle();
        drive_cycle();
        end_cycle();
    endtask

    task automatic do_reset(input string tag, input int new_lat);
        reset                = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = '0;
        pend.delete();
        #1;
        check({tag, "_rst_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_rst_if_valid"},  32'(bus.if_valid), 32'd0);
        check({tag, "_rst_count"},     32'(bus.fifo_count), 32'd0);
        check({tag, "_rst_if_pc"},     bus.if_pc, 32'd0);
        check({tag, "_rst_if_instr"},  bus.if_instr, 32'd0);
        @(posedge clock);
        @(negedge clock);
        cyc++;
        lat   = new_lat;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b1;

        // rdy redir rpc | req addr | if pc | count  (1-cycle memory)
        add(1, 0, 0,      1, 32'h000, 0, 0,      0);
        add(1, 0, 0,      1, 32'h004, 0, 0,      0);
        add(1, 0, 0,      1, 32'h008, 1, 32'h0,  1);
        add(0, 0, 0,      1, 32'h00C, 1, 32'h4,  1);
        add(0, 0, 0,      1, 32'h010, 1, 32'h4,  2);
        add(0, 0, 0,      0, 0,       1, 32'h4,  3);
        add(0, 0, 0,      0, 0,       1, 32'h4,  4);
        add(1, 0, 0,      0, 0,       1, 32'h4,  4);
        add(1, 0, 0,      1, 32'h014, 1, 32'h8,  3);
        add(1, 0, 0,      1, 32'h018, 1, 32'hC,  2);
        add(1, 0, 0,      1, 32'h01C, 1, 32'h10, 2);
        add(1, 0, 0,      1, 32'h020, 1, 32'h14, 2);
        add(1, 1, 32'h103, 0, 0,      0, 0,      2);
        add(1, 0, 0,      1, 32'h100, 0, 0,      0);
        add(1, 0, 0,      1, 32'h104, 0, 0,      0);
        add(1, 0, 0,      1, 32'h108, 1, 32'h100, 1);
        add(1, 0, 0,      1, 32'h10C, 1, 32'h104, 1);

        do_reset("tbl", 1);
        for (int i = 0; i < vq.size(); i++) begin
            bus.if_ready       = vq[i].rdy;
            bus.redirect_valid = vq[i].redir;
            bus.redirect_pc    = vq[i].rpc;
            drive_cycle();
            check($sformatf("row%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vq[i].e_req));
            if (vq[i].e_req)
                check($sformatf("row%0d_req_addr", i), bus.imem_req_addr, vq[i].e_addr);
            check($sformatf("row%0d_if_valid", i), 32'(bus.if_valid), 32'(vq[i].e_if));
            if (vq[i].e_if) begin
                check($sformatf("row%0d_if_pc", i), bus.if_pc, vq[i].e_pc);
                check($sformatf("row%0d_if_instr", i), bus.if_instr, mem_fn(vq[i].e_pc));
            end
            check($sformatf("row%0d_count", i), 32'(bus.fifo_count), 32'(vq[i].e_cnt));
            end_cycle();
        end
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b1;

        // 3-cycle memory: redirect with 3 requests in flight, one answering now
        do_reset("lat3", 3);
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            check($sformatf("lat3_c%0d_req_addr", c), bus.imem_req_addr, 32'(c * 4));
            end_cycle();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        drive_cycle();
        check("lat3_redir_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
        check("lat3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("lat3_redir_if_valid", 32'(bus.if_valid), 32'd0);
        end_cycle();
        bus.redirect_valid = 1'b0;
        for (int c = 4; c < 8; c++) begin
            drive_cycle();
            if (c == 4) begin
                check("lat3_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
                check("lat3_first_req_addr", bus.imem_req_addr, 32'h0000_0100);
            end
            check($sformatf("lat3_c%0d_count", c), 32'(bus.fifo_count), 32'd0);
            check($sformatf("lat3_c%0d_if_valid", c), 32'(bus.if_valid), 32'd0);
            end_cycle();
        end
        drive_cycle();
        check("lat3_first_if_valid", 32'(bus.if_valid), 32'd1);
        check("lat3_first_if_pc", bus.if_pc, 32'h0000_0100);
        check("lat3_first_if_instr", bus.if_instr, mem_fn(32'h0000_0100));
        end_cycle();
        drive_cycle();
        check("lat3_second_if_pc", bus.if_pc, 32'h0000_0104);
        end_cycle();

        // address wrap at the top of the 32-bit space
        do_reset("wrap", 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        cycle();
        bus.redirect_valid = 1'b0;
        drive_cycle();
        check("wrap_req_hi", bus.imem_req_addr, 32'hFFFF_FFFC);
        end_cycle();
        drive_cycle();
        check("wrap_req_lo", bus.imem_req_addr, 32'h0000_0000);
        end_cycle();
        drive_cycle();
        check("wrap_if_pc_hi", bus.if_pc, 32'hFFFF_FFFC);
        end_cycle();
        drive_cycle();
        check("wrap_if_pc_lo", bus.if_pc, 32'h0000_0000);
        check("wrap_if_instr_lo", bus.if_instr, mem_fn(32'h0000_0000));
        end_cycle();

        // stalled with every slot reserved, then reset mid-stream
        do_reset("midrst", 3);
        bus.if_ready = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        drive_cycle();
        check("midrst_count_before", 32'(bus.fifo_count), 32'd2);
        check("midrst_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        bus.if_ready = 1'b1;
        do_reset("midrst", 1);
        drive_cycle();
        check("midrst_first_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check("midrst_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        end_cycle();
        cycle();
        drive_cycle();
        check("midrst_if_pc", bus.if_pc, 32'h0000_0000);
        check("midrst_count_after", 32'(bus.fifo_count), 32'd1);
        end_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
